// File: rtl/multiplicador_saturado_param.sv
// Sequential shift-and-add multiplier, WIDTH+1 cycle fixed latency.
// Signed/unsigned modes, full 2W product, optional clamp on overflow.
module multiplicador_saturado_param #(
  parameter int WIDTH  = 8,
  parameter int SATURA = 1
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               START,
  input  logic               MODO,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [WIDTH-1:0]   Resultado,
  output logic [2*WIDTH-1:0] Produto,
  output logic               Overflow,
  output logic               Pronto,
  output logic               Ocupado
);

  localparam int P2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    OCIOSO,
    CALCULA,
    FINALIZA,
    PRONTO
  } state_t;

  state_t          state;
  logic [P2-1:0]   acc;
  logic [P2-1:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]   cnt;
  logic            sign_r;
  logic            modo_r;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [P2-1:0]    prod;
  logic [WIDTH:0]   top_s;
  logic             ovf;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] max_s;
  logic [WIDTH-1:0] min_s;

  // Operand magnitudes; |-2^(W-1)| fits as an unsigned W-bit value.
  always_comb begin
    a_abs = A;
    b_abs = B;
    if (MODO && A[WIDTH-1]) a_abs = WIDTH'(0) - A;
    if (MODO && B[WIDTH-1]) b_abs = WIDTH'(0) - B;
  end

  // Final product, overflow detection and saturated/wrapped result.
  always_comb begin
    max_s    = {1'b0, {(WIDTH-1){1'b1}}};
    min_s    = {1'b1, {(WIDTH-1){1'b0}}};
    prod     = sign_r ? (P2'(0) - acc) : acc;
    top_s    = prod[P2-1:WIDTH-1];
    ovf      = 1'b0;
    res_next = prod[WIDTH-1:0];
    if (modo_r) ovf = !((top_s == '0) || (top_s == '1));
    else        ovf = |prod[P2-1:WIDTH];
    if ((SATURA != 0) && ovf) begin
      if (!modo_r)          res_next = '1;
      else if (prod[P2-1])  res_next = min_s;
      else                  res_next = max_s;
    end
  end

  // Control FSM and datapath with registered outputs.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state     <= OCIOSO;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      sign_r    <= 1'b0;
      modo_r    <= 1'b0;
      Resultado <= '0;
      Produto   <= '0;
      Overflow  <= 1'b0;
      Pronto    <= 1'b0;
      Ocupado   <= 1'b0;
    end else begin
      unique case (state)
        OCIOSO, PRONTO: begin
          if (START) begin
            mcand   <= {{WIDTH{1'b0}}, a_abs};
            mplier  <= b_abs;
            sign_r  <= MODO & (A[WIDTH-1] ^ B[WIDTH-1]);
            modo_r  <= MODO;
            acc     <= '0;
            cnt     <= '0;
            Pronto  <= 1'b0;
            Ocupado <= 1'b1;
            state   <= CALCULA;
          end
        end
        CALCULA: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FINALIZA;
        end
        FINALIZA: begin
          Produto   <= prod;
          Overflow  <= ovf;
          Resultado <= res_next;
          Pronto    <= 1'b1;
          Ocupado   <= 1'b0;
          state     <= PRONTO;
        end
        default: state <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_saturado_param.sv
// Scoreboard bench: SATURA=1 and SATURA=0 instances share stimulus.
// Expected results come from integer arithmetic on the operands.
module tb_multiplicador_saturado_param;

  localparam int W = 8;

  logic         CLOCK = 1'b0;
  logic         RESET = 1'b0;
  logic         START = 1'b0;
  logic         MODO  = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;

  logic [W-1:0]   res_s, res_w;
  logic [2*W-1:0] prod_s, prod_w;
  logic           ovf_s, ovf_w;
  logic           pronto_s, pronto_w;
  logic           ocup_s, ocup_w;

  multiplicador_saturado_param #(.WIDTH(W), .SATURA(1)) dut_sat (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .MODO(MODO),
    .A(A), .B(B), .Resultado(res_s), .Produto(prod_s),
    .Overflow(ovf_s), .Pronto(pronto_s), .Ocupado(ocup_s)
  );

  multiplicador_saturado_param #(.WIDTH(W), .SATURA(0)) dut_wrap (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .MODO(MODO),
    .A(A), .B(B), .Resultado(res_w), .Produto(prod_w),
    .Overflow(ovf_w), .Pronto(pronto_w), .Ocupado(ocup_w)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [2*W-1:0] produto;
    logic           ovf;
    logic [W-1:0]   res_sat;
    logic [W-1:0]   res_wrap;
    int             start_cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge CLOCK) cyc++;

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b,
                                 logic m, int sc);
    exp_t   e;
    longint sa, sb, p;
    if (m) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    p = sa * sb;
    e.produto  = p[2*W-1:0];
    e.ovf      = m ? (p > 127 || p < -128) : (p > 255);
    e.res_wrap = p[W-1:0];
    if (!e.ovf)  e.res_sat = p[W-1:0];
    else if (!m) e.res_sat = 8'hFF;
    else         e.res_sat = (p < 0) ? 8'h80 : 8'h7F;
    e.start_cyc = sc;
    return e;
  endfunction

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: on each Pronto rise, pop and compare both instances.
  logic prev_pronto = 1'b0;
  always @(negedge CLOCK) begin
    exp_t e;
    if (pronto_s && !prev_pronto) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = q.pop_front();
        chk("latency", cyc - e.start_cyc, W + 1);
        chk("produto_sat", prod_s, e.produto);
        chk("overflow_sat", ovf_s, e.ovf);
        chk("resultado_sat", res_s, e.res_sat);
        chk("produto_wrap", prod_w, e.produto);
        chk("overflow_wrap", ovf_w, e.ovf);
        chk("resultado_wrap", res_w, e.res_wrap);
        chk("pronto_wrap", pronto_w, 1);
        chk("ocupado_done", ocup_s, 0);
      end
    end
    prev_pronto = pronto_s;
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge CLOCK);
    while (ocup_s && n < 100) begin
      @(negedge CLOCK);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 1, 0);
  endtask

  task automatic do_op(logic [W-1:0] a, logic [W-1:0] b, logic m);
    wait_idle();
    A = a; B = b; MODO = m; START = 1'b1;
    q.push_back(model(a, b, m, cyc + 1));
    @(negedge CLOCK);
    START = 1'b0;
    A = W'($urandom); B = W'($urandom); MODO = ~m;
    chk("ocupado_after_start", ocup_s, 1);
    chk("pronto_after_start", pronto_s, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [W-1:0] ta [12] = '{8'd12, 8'd20, 8'hFD, 8'h80, 8'h80, 8'd100,
                              8'hFF, 8'hFF, 8'h00, 8'h7F, 8'h81, 8'd15};
    logic [W-1:0] tb [12] = '{8'd10, 8'd20, 8'h05, 8'h01, 8'h80, 8'hFE,
                              8'h00, 8'hFF, 8'h00, 8'h7F, 8'h7F, 8'd17};
    logic         tm [12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                              1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int n;

    repeat (3) @(negedge CLOCK);
    chk("reset_resultado", res_s, 0);
    chk("reset_produto", prod_s, 0);
    chk("reset_overflow", ovf_s, 0);
    chk("reset_pronto", pronto_s, 0);
    chk("reset_ocupado", ocup_s, 0);
    RESET = 1'b1;
    @(negedge CLOCK);

    for (int i = 0; i < 12; i++) do_op(ta[i], tb[i], tm[i]);

    for (int i = 0; i < 60; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom));

    // Busy START with different operands must be ignored.
    do_op(8'd13, 8'd11, 1'b0);
    @(negedge CLOCK);
    A = 8'd200; B = 8'd200; MODO = 1'b1; START = 1'b1;
    @(negedge CLOCK);
    START = 1'b0;

    // Asynchronous reset mid-operation.
    do_op(8'd7, 8'd9, 1'b0);
    wait_idle();
    do_op(8'd33, 8'd3, 1'b0);
    repeat (4) @(negedge CLOCK);
    #2 RESET = 1'b0;
    #1;
    chk("abort_resultado", res_s, 0);
    chk("abort_produto", prod_s, 0);
    chk("abort_overflow", ovf_s, 0);
    chk("abort_pronto", pronto_s, 0);
    chk("abort_ocupado", ocup_s, 0);
    q.delete();
    @(negedge CLOCK);
    RESET = 1'b1;
    repeat (12) @(negedge CLOCK);
    chk("abort_no_result", pronto_s, 0);
    do_op(8'd21, 8'd5, 1'b0);

    // START held high: a new capture whenever the unit is idle.
    wait_idle();
    START = 1'b1;
    n = 0;
    while (n < 8) begin
      if (!ocup_s) begin
        A = W'($urandom); B = W'($urandom); MODO = 1'($urandom);
        q.push_back(model(A, B, MODO, cyc + 1));
        n++;
      end
      @(negedge CLOCK);
    end
    START = 1'b0;

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge CLOCK);
      n++;
    end
    chk("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplicador_saturado_param.md
Name: multiplicador_saturado_param

Overview:
- Parametrised sequential shift-and-add multiplier with optional saturation. Successor to the 8x8 repeated-addition multiplier.
- Fixed latency of WIDTH+1 cycles, independent of operand values. Supports unsigned and signed (two's complement) modes and exposes the full 2*WIDTH product.
- Sits in the ALU datapath as the MUL functional unit; the ALU controller drives it with a START/Pronto handshake.

Parameters:
- WIDTH, 8, operand and saturated-result width in bits (legal range 4..32).
- SATURA, 1, 1 = Resultado clamps on overflow; 0 = Resultado is the low WIDTH bits of the product (wrap), and Overflow is still reported.

Ports:
- CLOCK  input  1  single clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset; clears all state immediately.
- START  input  1  request pulse; sampled only when Ocupado=0.
- MODO  input  1  0 = unsigned, 1 = signed; captured with the operands at START.
- A  input  WIDTH  multiplicand; captured at START.
- B  input  WIDTH  multiplier; captured at START.
- Resultado  output  WIDTH  saturated or wrapped product; registered; valid while Pronto=1.
- Produto  output  2*WIDTH  exact product (signed or unsigned per MODO); registered; valid while Pronto=1.
- Overflow  output  1  product does not fit in WIDTH bits in the selected mode; valid while Pronto=1.
- Pronto  output  1  result valid; level signal, held until the next accepted START.
- Ocupado  output  1  operation in progress; START is ignored while high.

Behaviour:
- Reset (RESET=0, asynchronous): state OCIOSO; Resultado=0, Produto=0, Overflow=0, Pronto=0, Ocupado=0; internal accumulator, counter and operand registers all 0. Reset asserted mid-operation aborts the operation, and no result is produced.
- States: OCIOSO, CALCULA, FINALIZA, PRONTO.
  - OCIOSO or PRONTO, START=1 at edge E0: capture A, B and MODO.
    - In signed mode, store |A| and |B| as WIDTH-bit unsigned values (|-2^(W-1)| = 2^(W-1)) and store sign = A[W-1] XOR B[W-1]. In unsigned mode, sign = 0.
    - Clear the 2W-bit accumulator and set counter=0. Go to CALCULA.
    - Pronto=0 and Ocupado=1 from E0.
  - CALCULA, one iteration per edge:
    - If multiplier LSB = 1, accumulator += multiplicand (multiplicand held 2W bits wide, shifted left 1 per iteration). Multiplier shifts right 1.
    - counter += 1. At the edge where counter reaches WIDTH-1 → FINALIZA. This gives exactly WIDTH iterations, on edges E1..EW.
  - FINALIZA (edge E(W+1)): registers Produto, Overflow and Resultado. Pronto=1, Ocupado=0. Go to PRONTO.
    - Produto = sign ? -accumulator : accumulator (2W-bit two's complement).
    - Unsigned overflow: Produto[2W-1:W] != 0.
    - Signed overflow: Produto[2W-1:W-1] is not all zeros and not all ones.
    - SATURA=1 and overflow:
      - unsigned: Resultado = 2^W-1.
      - signed: Resultado = 2^(W-1)-1 if the product is positive, -2^(W-1) if negative.
    - Otherwise Resultado = Produto[W-1:0].
  - PRONTO: all outputs held. START → same capture as OCIOSO, and Pronto drops at that edge.
- Latency: Pronto rises exactly WIDTH+1 edges after the START-sampling edge, for every operand value, including 0.
- START while Ocupado=1: ignored. Operands, MODO and the operation in progress are unaffected.
- START held high continuously: a new operation begins on each edge where Ocupado=0. Pronto is then high for one cycle per result.
- A or B changing after capture: no effect on the current result.
- Result outputs (Resultado, Produto, Overflow) change only at FINALIZA or on reset. They do not clear on START; Pronto qualifies them.
- Arithmetic: no carry out of the 2W-bit accumulator is possible. The maximum unsigned magnitude product is (2^W-1)^2 < 2^(2W).

Test Plan (WIDTH=8, SATURA=1 unless stated):
- Unsigned 12*10: Pronto=1 exactly 9 edges after START. Resultado=120, Produto=120, Overflow=0. Ocupado is high for cycles 1..8.
- Unsigned overflow 20*20: Produto=400, Resultado=255, Overflow=1. With SATURA=0: Resultado=144 (0x90), Overflow=1.
- Signed -3*5 (0xFD, 0x05), MODO=1: Produto=0xFFF1, Resultado=0xF1, Overflow=0. Signed -128*1: Resultado=0x80, Overflow=0.
- Signed saturation:
  - -128*-128: Produto=16384, Resultado=0x7F, Overflow=1.
  - 100*-2: Produto=-200, Resultado=0x80, Overflow=1.
- Boundary: A=0xFF, B=0 unsigned → Resultado=0, Overflow=0, latency still 9. 255*255 unsigned → Produto=65025, Resultado=255, Overflow=1.
- Control:
  - START pulsed at cycle 3 of a busy op with different operands → ignored; the original result is delivered.
  - RESET=0 at cycle 5 (asynchronous, mid-cycle) → all outputs 0 immediately.
  - After release, a new START completes normally.
  - Back-to-back START held high gives a result every 10 cycles.
